// File: rtl/mem_arbiter.sv
// Three-way memory arbiter: store, load and instruction fetch share one memory port.
// Only one transaction is in flight at a time. A fetch that keeps losing is eventually forced through.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] ia,
    input  logic                  ia_enable,
    output logic [DATA_WIDTH-1:0] iv,
    output logic                  iv_valid,
    input  logic [DATA_WIDTH-1:0] da_in,
    input  logic                  da_in_enable,
    output logic [DATA_WIDTH-1:0] dv_in,
    output logic                  dv_in_valid,
    input  logic [DATA_WIDTH-1:0] da_out,
    input  logic                  da_out_enable,
    input  logic [DATA_WIDTH-1:0] dv_out,
    output logic                  dv_out_valid,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_readdatavalid
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_READ} state_t;
    typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    state_t     state, state_next;
    owner_t     owner, owner_next;
    logic [7:0] starve_count, starve_next;
    logic       fetch_req, load_req, store_req;
    logic       grant_fetch, grant, store_done, read_done;

    // A requester whose valid pulse is out this cycle is not re-granted until the next cycle.
    always_comb begin
        fetch_req   = ia_enable & ~iv_valid;
        load_req    = da_in_enable & ~dv_in_valid;
        store_req   = da_out_enable & ~dv_out_valid;
        grant_fetch = fetch_req && ((starve_count == STARVE_MAX) || (!store_req && !load_req));
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        starve_next = starve_count;
        grant       = 1'b0;
        store_done  = 1'b0;
        read_done   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_req || load_req || store_req) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                    if (grant_fetch)    owner_next = OWN_FETCH;
                    else if (store_req) owner_next = OWN_STORE;
                    else                owner_next = OWN_LOAD;
                end
                if (!fetch_req || grant_fetch) starve_next = 8'd0;
                else if (starve_count < STARVE_MAX) starve_next = starve_count + 8'd1;
            end
            ISSUE: begin
                mem_read  = (owner != OWN_STORE);
                mem_write = (owner == OWN_STORE);
                if (!mem_waitrequest) begin
                    if (owner == OWN_STORE) begin
                        store_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = WAIT_READ;
                    end
                end
                if (!ia_enable) starve_next = 8'd0;
            end
            WAIT_READ: begin
                if (mem_readdatavalid) begin
                    read_done  = 1'b1;
                    state_next = IDLE;
                end
                if (!ia_enable) starve_next = 8'd0;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            owner        <= OWN_FETCH;
            starve_count <= 8'd0;
        end else begin
            state        <= state_next;
            owner        <= owner_next;
            starve_count <= starve_next;
        end
    end

    // Command registers, delivered data and the one-cycle completion pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_address   <= '0;
            mem_writedata <= '0;
            iv            <= '0;
            dv_in         <= '0;
            iv_valid      <= 1'b0;
            dv_in_valid   <= 1'b0;
            dv_out_valid  <= 1'b0;
        end else begin
            iv_valid     <= 1'b0;
            dv_in_valid  <= 1'b0;
            dv_out_valid <= 1'b0;
            if (grant) begin
                case (owner_next)
                    OWN_FETCH: mem_address <= ia;
                    OWN_LOAD:  mem_address <= da_in;
                    default: begin
                        mem_address   <= da_out;
                        mem_writedata <= dv_out;
                    end
                endcase
            end
            if (store_done) dv_out_valid <= 1'b1;
            if (read_done) begin
                if (owner == OWN_FETCH) begin
                    iv       <= mem_readdata;
                    iv_valid <= 1'b1;
                end else begin
                    dv_in       <= mem_readdata;
                    dv_in_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a memory model with programmable stalls and read latency,
// a scoreboard of expected completions, a vector table and hand-written corner sequences.
module tb_mem_arbiter;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic        clock;
    logic        reset_n;
    logic [31:0] ia, da_in, da_out, dv_out;
    logic        ia_enable, da_in_enable, da_out_enable;
    logic [31:0] iv, dv_in, mem_address, mem_writedata, mem_readdata;
    logic        iv_valid, dv_in_valid, dv_out_valid;
    logic        mem_read, mem_write, mem_waitrequest, mem_readdatavalid;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ws;
        int          lat;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cfg_wait = 0;
    int          cfg_lat = 0;
    int          addr_unstable = 0;
    int          strobe_overlap = 0;
    logic [31:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    mem_arbiter #(.DATA_WIDTH(32), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .ia(ia), .ia_enable(ia_enable), .iv(iv), .iv_valid(iv_valid),
        .da_in(da_in), .da_in_enable(da_in_enable), .dv_in(dv_in), .dv_in_valid(dv_in_valid),
        .da_out(da_out), .da_out_enable(da_out_enable), .dv_out(dv_out), .dv_out_valid(dv_out_valid),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic pulse_of(input int kind);
        case (kind)
            K_FETCH: return iv_valid;
            K_LOAD:  return dv_in_valid;
            default: return dv_out_valid;
        endcase
    endfunction

    // Memory: read data is address ^ 0x5A5A0000; stalls cfg_wait cycles, answers cfg_lat cycles after accept.
    initial begin
        int          ws_left;
        bit          in_cmd;
        int          rd_countdown;
        logic [31:0] rd_pending;
        logic [31:0] cmd_addr, cmd_wdata;
        in_cmd = 0; ws_left = 0; rd_countdown = -1; rd_pending = '0;
        cmd_addr = '0; cmd_wdata = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        forever begin
            @(negedge clock);
            mem_readdatavalid = 1'b0;
            if (rd_countdown == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = rd_pending;
                rd_countdown      = -1;
            end else if (rd_countdown > 0) begin
                rd_countdown--;
            end
            if (mem_read && mem_write) strobe_overlap++;
            if (mem_read || mem_write) begin
                if (!in_cmd) begin
                    in_cmd = 1; ws_left = cfg_wait;
                    cmd_addr = mem_address; cmd_wdata = mem_writedata;
                end
                if (mem_address !== cmd_addr || (mem_write && mem_writedata !== cmd_wdata)) addr_unstable++;
                if (ws_left > 0) begin
                    mem_waitrequest = 1'b1;
                    ws_left--;
                end else begin
                    mem_waitrequest = 1'b0;
                    in_cmd = 0;
                    if (mem_write) begin
                        last_wr_addr = mem_address;
                        last_wr_data = mem_writedata;
                    end else begin
                        rd_pending   = mem_address ^ 32'h5A5A_0000;
                        rd_countdown = cfg_lat;
                    end
                end
            end else begin
                mem_waitrequest = 1'b0;
            end
        end
    end

    // Every valid pulse must match the oldest expected completion.
    initial begin
        exp_t e;
        int   cnt;
        int   kind;
        forever begin
            @(negedge clock);
            cnt = int'(iv_valid) + int'(dv_in_valid) + int'(dv_out_valid);
            if (cnt != 0) begin
                checkOutput("one_valid", cnt, 1);
                kind = dv_out_valid ? K_STORE : (dv_in_valid ? K_LOAD : K_FETCH);
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", kind, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_kind", kind, e.kind);
                    if (kind == K_STORE) begin
                        checkOutput("sb_wr_addr", last_wr_addr, e.addr);
                        checkOutput("sb_wr_data", last_wr_data, e.data);
                    end else if (kind == K_LOAD) begin
                        checkOutput("sb_dv_in", dv_in, e.data);
                    end else begin
                        checkOutput("sb_iv", iv, e.data);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_data, input int exp_lat, input string name);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clock);
        e.kind = kind;
        e.addr = addr;
        e.data = exp_data;
        sb.push_back(e);
        case (kind)
            K_FETCH: begin ia = addr; ia_enable = 1'b1; end
            K_LOAD:  begin da_in = addr; da_in_enable = 1'b1; end
            default: begin da_out = addr; dv_out = wdata; da_out_enable = 1'b1; end
        endcase
        seen = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            n = i;
            if (pulse_of(kind)) begin
                seen = 1;
                break;
            end
        end
        if (!seen) n = 99;
        ia_enable = 1'b0; da_in_enable = 1'b0; da_out_enable = 1'b0;
        checkOutput({name, "_latency"}, n, exp_lat);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   npulses;
        bit   seen;
        exp_t e;

        vecs[0] = '{K_STORE, 32'h0000_0100, 32'h0000_CAFE, 0, 0, 32'h0000_CAFE, 2};
        vecs[1] = '{K_LOAD,  32'h0000_0200, 32'h0,         0, 0, 32'h5A5A_0200, 3};
        vecs[2] = '{K_FETCH, 32'h0000_0300, 32'h0,         0, 0, 32'h5A5A_0300, 3};
        vecs[3] = '{K_LOAD,  32'h1234_0004, 32'h0,         2, 0, 32'h486E_0004, 5};
        vecs[4] = '{K_FETCH, 32'h0000_0ABC, 32'h0,         1, 2, 32'h5A5A_0ABC, 6};
        vecs[5] = '{K_STORE, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 3, 0, 32'hDEAD_BEEF, 5};
        vecs[6] = '{K_LOAD,  32'h5A5A_1234, 32'h0,         5, 1, 32'h0000_1234, 9};

        reset_n = 1'b0;
        ia = '0; da_in = '0; da_out = '0; dv_out = '0;
        ia_enable = 1'b0; da_in_enable = 1'b0; da_out_enable = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("rst_mem_address", mem_address, 0);
        checkOutput("rst_strobes", {mem_read, mem_write, iv_valid, dv_in_valid, dv_out_valid}, 0);
        checkOutput("rst_iv", iv, 0);
        checkOutput("rst_dv_in", dv_in, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cfg_wait = vecs[i].ws;
            cfg_lat  = vecs[i].lat;
            applyStimulus(vecs[i].kind, vecs[i].addr, vecs[i].wdata, vecs[i].exp_data,
                          vecs[i].exp_lat, $sformatf("vec%0d", i));
        end
        cfg_wait = 0;
        cfg_lat  = 0;
        repeat (3) @(negedge clock);
        checkOutput("hold_dv_in", dv_in, 32'h0000_1234);
        checkOutput("hold_iv", iv, 32'h5A5A_0ABC);

        // All three at once: store, then load, then fetch; each drops its enable on its pulse.
        @(negedge clock);
        e = '{K_STORE, 32'h0000_0A00, 32'h0000_7777}; sb.push_back(e);
        e = '{K_LOAD,  32'h0000_0B00, 32'h5A5A_0B00}; sb.push_back(e);
        e = '{K_FETCH, 32'h0000_0C00, 32'h5A5A_0C00}; sb.push_back(e);
        da_out = 32'h0A00; dv_out = 32'h7777; da_in = 32'h0B00; ia = 32'h0C00;
        da_out_enable = 1'b1; da_in_enable = 1'b1; ia_enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (dv_out_valid) da_out_enable = 1'b0;
            if (dv_in_valid) da_in_enable = 1'b0;
            if (iv_valid) ia_enable = 1'b0;
            if (!da_out_enable && !da_in_enable && !ia_enable) break;
        end
        checkOutput("all3_drained", sb.size(), 0);
        da_out_enable = 1'b0; da_in_enable = 1'b0; ia_enable = 1'b0;

        // Load enable dropped after one cycle still completes.
        @(negedge clock);
        e = '{K_LOAD, 32'h0000_0900, 32'h5A5A_0900}; sb.push_back(e);
        da_in = 32'h0900; da_in_enable = 1'b1;
        @(negedge clock);
        da_in_enable = 1'b0;
        seen = 0;
        npulses = 99;
        for (int i = 2; i <= 20; i++) begin
            @(negedge clock);
            if (dv_in_valid) begin
                seen = 1;
                npulses = i;
                break;
            end
        end
        checkOutput("drop_latency", npulses, 3);

        // Store and load keep the port busy; fetch must be forced through on the 9th decision.
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            e = '{K_STORE, 32'h0000_0500, 32'h0000_1111}; sb.push_back(e);
            e = '{K_LOAD,  32'h0000_0600, 32'h5A5A_0600}; sb.push_back(e);
        end
        e = '{K_FETCH, 32'h0000_0700, 32'h5A5A_0700}; sb.push_back(e);
        da_out = 32'h0500; dv_out = 32'h1111; da_in = 32'h0600; ia = 32'h0700;
        da_out_enable = 1'b1; da_in_enable = 1'b1; ia_enable = 1'b1;
        npulses = 0;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (iv_valid) begin
                seen = 1;
                break;
            end
            if (dv_out_valid || dv_in_valid) npulses++;
        end
        da_out_enable = 1'b0; da_in_enable = 1'b0; ia_enable = 1'b0;
        checkOutput("starve_fetch_seen", seen, 1);
        checkOutput("starve_pulses", npulses, 8);
        repeat (3) @(negedge clock);
        sb.delete();

        // Reset in WAIT_READ, stray readdatavalid afterwards must be dropped.
        cfg_lat = 3;
        @(negedge clock);
        da_in = 32'h0000_0800; da_in_enable = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        da_in_enable = 1'b0;
        #1;
        checkOutput("midrst_mem_address", mem_address, 0);
        checkOutput("midrst_mem_writedata", mem_writedata, 0);
        checkOutput("midrst_strobes", {mem_read, mem_write, iv_valid, dv_in_valid, dv_out_valid}, 0);
        checkOutput("midrst_iv", iv, 0);
        checkOutput("midrst_dv_in", dv_in, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        cfg_lat = 0;
        checkOutput("post_rst_dv_in", dv_in, 0);
        checkOutput("post_rst_iv", iv, 0);
        applyStimulus(K_LOAD, 32'h0000_0D00, 32'h0, 32'h5A5A_0D00, 3, "post_rst_load");
        applyStimulus(K_STORE, 32'h0000_0E00, 32'h0000_BEEF, 32'h0000_BEEF, 2, "post_rst_store");

        repeat (4) @(negedge clock);
        checkOutput("sb_drained", sb.size(), 0);
        checkOutput("addr_stable", addr_unstable, 0);
        checkOutput("strobe_overlap", strobe_overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 8, maximum consecutive IDLE decision cycles a pending fetch request is denied before it is forced to win; legal range 1-255.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ia  input  regval_t  fetch address from core.
REQ-005 ia_enable  input  1  fetch request; held high until iv_valid.
REQ-006 iv  output  regval_t  fetch data to core.
REQ-007 iv_valid  output  1  one-cycle pulse; iv valid this cycle.
REQ-008 da_in  input  regval_t  load address from core.
REQ-009 da_in_enable  input  1  load request; held high until dv_in_valid.
REQ-010 dv_in  output  regval_t  load data to core.
REQ-011 dv_in_valid  output  1  one-cycle pulse; dv_in valid this cycle.
REQ-012 da_out  input  regval_t  store address from core.
REQ-013 da_out_enable  input  1  store request; held high until dv_out_valid.
REQ-014 dv_out  input  regval_t  store data from core.
REQ-015 dv_out_valid  output  1  one-cycle pulse; store accepted by memory.
REQ-016 mem_address  output  regval_t  shared memory address.
REQ-017 mem_read  output  1  memory read strobe.
REQ-018 mem_write  output  1  memory write strobe.
REQ-019 mem_writedata  output  regval_t  memory write data.
REQ-020 mem_waitrequest  input  1  memory stall; command held while high.
REQ-021 mem_readdata  input  regval_t  memory read data.
REQ-022 mem_readdatavalid  input  1  mem_readdata valid this cycle.

Function
REQ-023 The block SHALL implement states IDLE, ISSUE, WAIT_READ; exactly one transaction outstanding at any time.
REQ-024 In IDLE with any enable high, the block SHALL latch owner, address and (for store) dv_out into registers and move to ISSUE; with no enable high, stay in IDLE.
REQ-025 Priority SHALL be store > load > fetch, except a fetch SHALL win when the starve counter equals STARVE_LIMIT.
REQ-026 Starve counter: increments (saturating at STARVE_LIMIT) in each IDLE cycle where ia_enable is high and fetch loses; clears when fetch is granted or ia_enable is low.
REQ-027 In ISSUE, mem_read (load/fetch) or mem_write (store) SHALL be high with latched mem_address/mem_writedata, held stable while mem_waitrequest is high.
REQ-028 ISSUE with mem_waitrequest low: store SHALL pulse dv_out_valid next cycle and return to IDLE; load/fetch SHALL move to WAIT_READ.
REQ-029 In WAIT_READ, on mem_readdatavalid the block SHALL, next cycle, drive captured data on dv_in or iv for the latched owner with its valid pulse for exactly one cycle, and return to IDLE.
REQ-030 mem_readdatavalid outside WAIT_READ SHALL be ignored.
REQ-031 Minimum latency, request to valid pulse, zero wait states and zero-cycle memory read latency: store 2 cycles, load/fetch 3 cycles.
REQ-032 The cycle a valid pulse is driven SHALL be an IDLE cycle; the completing requester's enable in that cycle SHALL be ignored, so back-to-back requests from one requester have one idle cycle between transactions.
REQ-033 A requester dropping enable mid-transaction SHALL not abort it; the transaction completes and its valid pulse still fires.
REQ-034 mem_read and mem_write SHALL never be high together; both SHALL be low outside ISSUE.
REQ-035 iv and dv_in SHALL hold their last delivered value between pulses.

Reset
REQ-036 reset_n low SHALL immediately force IDLE, starve counter 0, and all outputs (iv, dv_in, mem_address, mem_writedata, all strobes and valids) to 0, including mid-transaction; an in-flight memory response after reset release SHALL be discarded per REQ-030.

Verification
REQ-037 Store only: da_out=0x100, dv_out=0xCAFE, waitrequest low -> mem_write with addr 0x100/data 0xCAFE one cycle, dv_out_valid pulse two cycles after request.
REQ-038 All three enables high together -> grant order store, load, fetch; exactly one valid pulse per transaction, no overlapping strobes.
REQ-039 Load and fetch continuously requested, STARVE_LIMIT=8 -> fetch granted no later than the 9th IDLE decision cycle.
REQ-040 Load with mem_waitrequest high 5 cycles, readdata 0x1234 valid 2 cycles after accept -> address stable throughout, dv_in=0x1234 with dv_in_valid one cycle, iv_valid stays 0.
REQ-041 reset_n low during WAIT_READ, stray mem_readdatavalid after release -> all outputs 0, no valid pulse, next request serviced normally.
